// File: rtl/touch_multi_led_ctrl_pkg.sv
// Shared definitions for the multi-channel touch key / LED controller:
// mode encodings, per-channel press FSM states and a counter width helper.
package touch_multi_led_ctrl_pkg;

   localparam logic [1:0] MODE_TOGGLE    = 2'b00;
   localparam logic [1:0] MODE_MOMENT    = 2'b01;
   localparam logic [1:0] MODE_SHORTLONG = 2'b10;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      PRESSED = 2'b01,
      LONG    = 2'b10
   } press_state_e;

   // A terminal count of 1 still needs a 1-bit counter.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/touch_multi_led_ctrl_chan.sv
// One touch channel: 2-FF synchroniser, debounce filter, press FSM
// (idle/pressed/long) and the mode-dependent LED rule.
module touch_key_chan
   import touch_multi_led_ctrl_pkg::*;
#(
   parameter int   DEB_CYC   = 1_000_000,
   parameter int   LONG_CYC  = 25_000_000,
   parameter logic TOUCH_ACT = 1'b1,
   parameter logic LED_INIT  = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       touch_key,
   input  logic [1:0] mode,
   output logic       led,
   output logic       key_press,
   output logic       key_long
);

   localparam int            DW        = cnt_width(DEB_CYC);
   localparam int            HW        = cnt_width(LONG_CYC);
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYC - 1);
   localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYC - 1);

   logic [1:0]    sync_q, sync_d;
   logic          key_s;
   logic          stable_q, stable_d;
   logic          stable_dly_q, stable_dly_d;
   logic [DW-1:0] deb_cnt_q, deb_cnt_d;
   logic          press_ev_q, press_ev_d;
   logic          rel_ev_q, rel_ev_d;
   press_state_e  state_q, state_d;
   logic [HW-1:0] hold_cnt_q, hold_cnt_d;
   logic          long_ev_q, long_ev_d;
   logic          led_q, led_d;

   always_comb begin
      sync_d       = {sync_q[0], touch_key};
      key_s        = sync_q[1];
      stable_d     = stable_q;
      deb_cnt_d    = '0;
      if (key_s != stable_q) begin
         if (deb_cnt_q == DEB_LAST) begin
            stable_d  = key_s;
            deb_cnt_d = '0;
         end else begin
            deb_cnt_d = deb_cnt_q + DW'(1);
         end
      end else begin
         deb_cnt_d = '0;
      end
      // Events fire one cycle after the filtered level has moved.
      stable_dly_d = stable_q;
      press_ev_d   = (stable_q == TOUCH_ACT) && (stable_dly_q != TOUCH_ACT);
      rel_ev_d     = (stable_q != TOUCH_ACT) && (stable_dly_q == TOUCH_ACT);
   end

   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      long_ev_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (press_ev_q) begin
               state_d    = PRESSED;
               hold_cnt_d = '0;
            end else begin
               state_d    = IDLE;
            end
         end
         PRESSED: begin
            if (rel_ev_q) begin
               state_d    = IDLE;
            end else if (hold_cnt_q == LONG_LAST) begin
               state_d    = LONG;
               long_ev_d  = 1'b1;
            end else begin
               hold_cnt_d = hold_cnt_q + HW'(1);
            end
         end
         LONG: begin
            if (rel_ev_q) begin
               state_d = IDLE;
            end else begin
               state_d = LONG;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      led_d = led_q;
      case (mode)
         MODE_MOMENT: begin
            led_d = LED_INIT ^ (stable_q == TOUCH_ACT);
         end
         MODE_SHORTLONG: begin
            // A release after the long threshold leaves the LED alone.
            if ((state_q == PRESSED) && rel_ev_q) begin
               led_d = ~led_q;
            end else if (long_ev_d) begin
               led_d = LED_INIT;
            end else begin
               led_d = led_q;
            end
         end
         default: begin
            if (press_ev_q) begin
               led_d = ~led_q;
            end else begin
               led_d = led_q;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q       <= {2{~TOUCH_ACT}};
         stable_q     <= ~TOUCH_ACT;
         stable_dly_q <= ~TOUCH_ACT;
         deb_cnt_q    <= '0;
         press_ev_q   <= 1'b0;
         rel_ev_q     <= 1'b0;
      end else begin
         sync_q       <= sync_d;
         stable_q     <= stable_d;
         stable_dly_q <= stable_dly_d;
         deb_cnt_q    <= deb_cnt_d;
         press_ev_q   <= press_ev_d;
         rel_ev_q     <= rel_ev_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         hold_cnt_q <= '0;
         long_ev_q  <= 1'b0;
         led_q      <= LED_INIT;
      end else begin
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
         long_ev_q  <= long_ev_d;
         led_q      <= led_d;
      end
   end

   assign led       = led_q;
   assign key_press = press_ev_q;
   assign key_long  = long_ev_q;

endmodule

// File: rtl/touch_multi_led_ctrl.sv
// Multi-channel touch key front end: one independent touch_key_chan per
// key/LED pair, all sharing the same mode input.
module touch_multi_led_ctrl
   import touch_multi_led_ctrl_pkg::*;
#(
   parameter int   CH_NUM    = 4,
   parameter int   DEB_CYC   = 1_000_000,
   parameter int   LONG_CYC  = 25_000_000,
   parameter logic TOUCH_ACT = 1'b1,
   parameter logic LED_INIT  = 1'b1
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic [CH_NUM-1:0] touch_key,
   input  logic [1:0]        mode,
   output logic [CH_NUM-1:0] led,
   output logic [CH_NUM-1:0] key_press,
   output logic [CH_NUM-1:0] key_long
);

   for (genvar g = 0; g < CH_NUM; g++) begin : g_chan
      touch_key_chan #(
         .DEB_CYC   (DEB_CYC),
         .LONG_CYC  (LONG_CYC),
         .TOUCH_ACT (TOUCH_ACT),
         .LED_INIT  (LED_INIT)
      ) u_chan (
         .clk       (sys_clk),
         .rst       (sys_rst),
         .touch_key (touch_key[g]),
         .mode      (mode),
         .led       (led[g]),
         .key_press (key_press[g]),
         .key_long  (key_long[g])
      );
   end

endmodule

// File: tb/tb_touch_multi_led_ctrl.sv
// Directed bench for touch_multi_led_ctrl: a table of press vectors plus
// hand-written sequences for latency, bounce, momentary mode and reset.
module tb_touch_multi_led_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] touch_key = 4'b0000;
   logic [1:0] mode = 2'b00;
   logic [3:0] led, key_press, key_long;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int press_cnt[4] = '{default: 0};
   int long_cnt[4]  = '{default: 0};
   int last_press[4] = '{default: 0};
   int p0[4];
   int l0[4];
   int t0;
   int lat;

   typedef struct {
      logic [1:0] mode;
      logic [3:0] mask;
      int         hold;
      logic [3:0] led;
      logic [3:0] prs;
      logic [3:0] lng;
   } vec_t;
   vec_t vecs[10];

   always #5 clk = ~clk;

   touch_multi_led_ctrl #(
      .CH_NUM    (4),
      .DEB_CYC   (4),
      .LONG_CYC  (16),
      .TOUCH_ACT (1'b1),
      .LED_INIT  (1'b1)
   ) dut (
      .sys_clk   (clk),
      .sys_rst   (rst),
      .touch_key (touch_key),
      .mode      (mode),
      .led       (led),
      .key_press (key_press),
      .key_long  (key_long)
   );

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (key_press[i]) begin
            press_cnt[i]  <= press_cnt[i] + 1;
            last_press[i] <= cyc;
         end
         if (key_long[i]) long_cnt[i] <= long_cnt[i] + 1;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic snap();
      for (int i = 0; i < 4; i++) begin
         p0[i] = press_cnt[i];
         l0[i] = long_cnt[i];
      end
   endtask

   // Per-channel pulse counts since the last snap, one byte per channel.
   task automatic chk_cnt(input string name, input logic [3:0] exp_p, input logic [3:0] exp_l);
      logic [31:0] gp, gl, ep, el;
      for (int i = 0; i < 4; i++) begin
         gp[i*8 +: 8] = 8'(press_cnt[i] - p0[i]);
         gl[i*8 +: 8] = 8'(long_cnt[i] - l0[i]);
         ep[i*8 +: 8] = {7'b0000000, exp_p[i]};
         el[i*8 +: 8] = {7'b0000000, exp_l[i]};
      end
      chk({name, "_press"}, gp, ep);
      chk({name, "_long"}, gl, el);
   endtask

   initial begin
      vecs[0] = '{2'b00, 4'b0001, 12, 4'b1110, 4'b0001, 4'b0000};
      vecs[1] = '{2'b00, 4'b0001, 12, 4'b1111, 4'b0001, 4'b0000};
      vecs[2] = '{2'b00, 4'b1111, 12, 4'b0000, 4'b1111, 4'b0000};
      vecs[3] = '{2'b00, 4'b1111, 12, 4'b1111, 4'b1111, 4'b0000};
      vecs[4] = '{2'b11, 4'b0100, 12, 4'b1011, 4'b0100, 4'b0000};
      vecs[5] = '{2'b10, 4'b1000, 10, 4'b0011, 4'b1000, 4'b0000};
      vecs[6] = '{2'b10, 4'b1000, 40, 4'b1011, 4'b1000, 4'b1000};
      vecs[7] = '{2'b10, 4'b0100, 40, 4'b1111, 4'b0100, 4'b0100};
      vecs[8] = '{2'b01, 4'b0010, 30, 4'b1111, 4'b0010, 4'b0010};
      vecs[9] = '{2'b00, 4'b0001, 40, 4'b1110, 4'b0001, 4'b0001};

      tick(3);
      chk("reset_led", {28'd0, led}, 32'h0000_000f);
      chk("reset_press", {28'd0, key_press}, 32'h0000_0000);
      chk("reset_long", {28'd0, key_long}, 32'h0000_0000);
      rst = 1'b0;
      snap();
      tick(100);
      chk_cnt("idle", 4'b0000, 4'b0000);
      chk("idle_led", {28'd0, led}, 32'h0000_000f);

      for (int v = 0; v < 10; v++) begin
         mode = vecs[v].mode;
         tick(2);
         snap();
         touch_key = vecs[v].mask;
         tick(vecs[v].hold);
         touch_key = 4'b0000;
         tick(20);
         chk($sformatf("vec%0d_led", v), {28'd0, led}, {28'd0, vecs[v].led});
         chk_cnt($sformatf("vec%0d", v), vecs[v].prs, vecs[v].lng);
      end

      // Press latency from raw edge.
      mode = 2'b00;
      tick(2);
      snap();
      t0 = cyc;
      touch_key[0] = 1'b1;
      tick(12);
      lat = last_press[0] - t0;
      chk_cnt("latency", 4'b0001, 4'b0000);
      chk("latency_7_to_8", {31'd0, (lat >= 7) && (lat <= 8)}, 32'd1);
      touch_key[0] = 1'b0;
      tick(20);
      chk("latency_led", {28'd0, led}, 32'h0000_000f);

      // Bounce shorter than the debounce window is ignored.
      snap();
      for (int k = 0; k < 5; k++) begin
         touch_key[1] = 1'b1;
         tick(3);
         touch_key[1] = 1'b0;
         tick(2);
      end
      tick(10);
      chk_cnt("bounce", 4'b0000, 4'b0000);
      chk("bounce_led", {28'd0, led}, 32'h0000_000f);
      snap();
      touch_key[1] = 1'b1;
      tick(10);
      touch_key[1] = 1'b0;
      tick(20);
      chk_cnt("bounce_hold", 4'b0010, 4'b0000);
      chk("bounce_hold_led", {28'd0, led}, 32'h0000_000d);

      // Momentary mode: entry snaps, held inverts, leaving keeps.
      mode = 2'b01;
      tick(1);
      chk("moment_snap", {28'd0, led}, 32'h0000_000f);
      snap();
      touch_key[2] = 1'b1;
      tick(15);
      chk("moment_held", {28'd0, led}, 32'h0000_000b);
      tick(15);
      touch_key[2] = 1'b0;
      tick(7);
      chk("moment_release", {28'd0, led}, 32'h0000_000f);
      tick(20);
      chk_cnt("moment", 4'b0100, 4'b0100);
      touch_key[2] = 1'b1;
      tick(15);
      chk("moment_held2", {28'd0, led}, 32'h0000_000b);
      mode = 2'b00;
      tick(2);
      chk("moment_leave", {28'd0, led}, 32'h0000_000b);
      touch_key[2] = 1'b0;
      tick(20);
      chk("moment_leave_rel", {28'd0, led}, 32'h0000_000b);

      // Reset while a key is held, then the held key re-presses.
      touch_key[3] = 1'b1;
      tick(10);
      chk("midpress_led", {28'd0, led}, 32'h0000_0003);
      rst = 1'b1;
      #1;
      chk("midreset_led", {28'd0, led}, 32'h0000_000f);
      chk("midreset_press", {28'd0, key_press}, 32'h0000_0000);
      chk("midreset_long", {28'd0, key_long}, 32'h0000_0000);
      tick(3);
      rst = 1'b0;
      snap();
      t0 = cyc;
      tick(12);
      lat = last_press[3] - t0;
      chk_cnt("repress", 4'b1000, 4'b0000);
      chk("repress_7_to_8", {31'd0, (lat >= 7) && (lat <= 8)}, 32'd1);
      chk("repress_led", {28'd0, led}, 32'h0000_0007);
      touch_key[3] = 1'b0;
      tick(20);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
